// File: rtl/cva6_gshare_bht_if.sv
// Prediction and update bundle between the frontend and the gshare branch history table.
// The frontend drives the master side; the predictor is the slave.
interface cva6_gshare_bht_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned BHT_HIST = 3
);
  logic                flush_bp_i;
  logic                debug_mode_i;
  logic                vpc_valid_i;
  logic [XLEN-1:0]     vpc_i;
  logic                bht_pred_valid_o;
  logic                bht_pred_taken_o;
  logic [BHT_HIST-1:0] bht_hist_o;
  logic [BHT_HIST-1:0] ghr_o;
  logic                upd_valid_i;
  logic [XLEN-1:0]     upd_pc_i;
  logic                upd_taken_i;
  logic [BHT_HIST-1:0] upd_hist_i;

  modport master (
    output flush_bp_i, debug_mode_i, vpc_valid_i, vpc_i,
    output upd_valid_i, upd_pc_i, upd_taken_i, upd_hist_i,
    input  bht_pred_valid_o, bht_pred_taken_o, bht_hist_o, ghr_o
  );

  modport slave (
    input  flush_bp_i, debug_mode_i, vpc_valid_i, vpc_i,
    input  upd_valid_i, upd_pc_i, upd_taken_i, upd_hist_i,
    output bht_pred_valid_o, bht_pred_taken_o, bht_hist_o, ghr_o
  );
endinterface

// File: rtl/cva6_gshare_bht.sv
// Gshare branch history table: 2-bit saturating counters indexed by PC XOR global history.
// The history used for a lookup is handed out with the prediction and returned on update,
// so the update lands on exactly the entry that produced the prediction.
module cva6_gshare_bht #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 32,
  parameter int unsigned BHT_HIST    = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  cva6_gshare_bht_if.slave       bp
);
  localparam int unsigned LOG_E = $clog2(BHT_ENTRIES);

  logic [1:0]             cnt_q [BHT_ENTRIES];
  logic [1:0]             cnt_d [BHT_ENTRIES];
  logic [BHT_ENTRIES-1:0] vld_q, vld_d;
  logic [BHT_HIST-1:0]    ghr_q, ghr_d;
  logic [BHT_HIST-1:0]    ghr_shift;
  logic [LOG_E-1:0]       ridx, widx;
  logic                   upd_en;

  // History shifted left with the resolved direction entering at bit 0.
  if (BHT_HIST == 1) begin : g_hist1
    assign ghr_shift = bp.upd_taken_i;
  end else begin : g_histn
    assign ghr_shift = {ghr_q[BHT_HIST-2:0], bp.upd_taken_i};
  end

  assign ridx   = bp.vpc_i[LOG_E+1:2] ^ LOG_E'(ghr_q);
  assign widx   = bp.upd_pc_i[LOG_E+1:2] ^ LOG_E'(bp.upd_hist_i);
  assign upd_en = bp.upd_valid_i & ~bp.debug_mode_i & ~bp.flush_bp_i;

  // Lookup reads only registered state, so a same-cycle update is never bypassed.
  always_comb begin
    bp.bht_pred_valid_o = bp.vpc_valid_i & vld_q[ridx];
    bp.bht_pred_taken_o = bp.vpc_valid_i & vld_q[ridx] & cnt_q[ridx][1];
    bp.bht_hist_o       = ghr_q;
    bp.ghr_o            = ghr_q;
  end

  // Next state: flush beats update; a first write seeds the counter weakly toward the outcome.
  always_comb begin
    cnt_d = cnt_q;
    vld_d = vld_q;
    ghr_d = ghr_q;
    if (bp.flush_bp_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        cnt_d[i] = 2'b01;
      end
      vld_d = '0;
      ghr_d = '0;
    end else if (upd_en) begin
      if (!vld_q[widx]) begin
        cnt_d[widx] = bp.upd_taken_i ? 2'b10 : 2'b01;
      end else if (bp.upd_taken_i) begin
        if (cnt_q[widx] != 2'b11) cnt_d[widx] = cnt_q[widx] + 2'd1;
      end else begin
        if (cnt_q[widx] != 2'b00) cnt_d[widx] = cnt_q[widx] - 2'd1;
      end
      vld_d[widx] = 1'b1;
      ghr_d       = ghr_shift;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        cnt_q[i] <= 2'b01;
      end
      vld_q <= '0;
      ghr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      ghr_q <= ghr_d;
    end
  end
endmodule

// File: tb/tb_cva6_gshare_bht.sv
// Directed bench for the gshare BHT with hand-computed expectations.
module tb_cva6_gshare_bht;
  logic clk_i;
  logic rst_i;
  int   n_tests;
  int   n_fail;
  logic [2:0] ghr_m;

  cva6_gshare_bht_if #(.XLEN(32), .BHT_HIST(3)) bp_if ();

  cva6_gshare_bht #(.XLEN(32), .BHT_ENTRIES(32), .BHT_HIST(3)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bp    (bp_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_lookup(input string tag, input logic [31:0] pc,
                              input logic exp_v, input logic exp_t, input logic [2:0] exp_h);
    bp_if.vpc_valid_i = 1'b1;
    bp_if.vpc_i       = pc;
    #1;
    check({tag, "_valid"}, 32'(bp_if.bht_pred_valid_o), 32'(exp_v));
    check({tag, "_taken"}, 32'(bp_if.bht_pred_taken_o), 32'(exp_t));
    check({tag, "_hist"},  32'(bp_if.bht_hist_o),       32'(exp_h));
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic t, input logic [2:0] h);
    bp_if.upd_valid_i = v;
    bp_if.upd_pc_i    = pc;
    bp_if.upd_taken_i = t;
    bp_if.upd_hist_i  = h;
  endtask

  initial begin
    logic [8:0] sat_exp;
    n_tests = 0;
    n_fail  = 0;
    ghr_m   = 3'd0;
    rst_i   = 1'b1;
    bp_if.flush_bp_i   = 1'b0;
    bp_if.debug_mode_i = 1'b0;
    bp_if.vpc_valid_i  = 1'b0;
    bp_if.vpc_i        = '0;
    set_upd(1'b0, 32'h0, 1'b0, 3'd0);

    // Reset state
    #12;
    check_lookup("reset", 32'h8000_0010, 1'b0, 1'b0, 3'd0);
    check("reset_ghr", 32'(bp_if.ghr_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // First taken update; same-cycle lookup to the same invalid entry sees the old state
    set_upd(1'b1, 32'h8000_0010, 1'b1, 3'd0);
    check_lookup("same_cycle", 32'h8000_0010, 1'b0, 1'b0, 3'd0);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 3'd0);
    ghr_m = 3'b001;
    check("ghr_after_first", 32'(bp_if.ghr_o), 32'(ghr_m));
    check_lookup("hit_idx4", 32'h8000_0014, 1'b1, 1'b1, 3'd1);
    check_lookup("miss_idx5", 32'h8000_0010, 1'b0, 1'b0, 3'd1);

    // Saturation walk on idx 16: 10,11,11,11,10,01,00,00,00 -> taken bit below
    sat_exp = 9'b000011111;
    for (int i = 0; i < 9; i++) begin
      set_upd(1'b1, 32'h8000_0040, (i < 4), 3'd0);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 3'd0);
      ghr_m = {ghr_m[1:0], (i < 4)};
      check($sformatf("sat_ghr_%0d", i), 32'(bp_if.ghr_o), 32'(ghr_m));
      check_lookup($sformatf("sat_%0d", i),
                   32'h8000_0000 | (32'(5'd16 ^ {2'b00, ghr_m}) << 2),
                   1'b1, sat_exp[i], ghr_m);
    end

    // Flush with a simultaneous taken update: everything cleared, update dropped
    bp_if.flush_bp_i = 1'b1;
    set_upd(1'b1, 32'h8000_0020, 1'b1, 3'd0);
    tick();
    bp_if.flush_bp_i = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 3'd0);
    ghr_m = 3'd0;
    check("flush_ghr", 32'(bp_if.ghr_o), 32'd0);
    check_lookup("flush_idx4", 32'h8000_0010, 1'b0, 1'b0, 3'd0);
    check_lookup("flush_idx16", 32'h8000_0040, 1'b0, 1'b0, 3'd0);
    check_lookup("flush_idx8", 32'h8000_0020, 1'b0, 1'b0, 3'd0);

    // Debug freeze: seed idx4 with 10, then three not-taken updates must be ignored
    set_upd(1'b1, 32'h8000_0010, 1'b1, 3'd0);
    tick();
    ghr_m = 3'b001;
    bp_if.debug_mode_i = 1'b1;
    set_upd(1'b1, 32'h8000_0014, 1'b0, 3'd1);
    check_lookup("debug_lookup", 32'h8000_0014, 1'b1, 1'b1, 3'd1);
    repeat (3) tick();
    check("debug_ghr", 32'(bp_if.ghr_o), 32'(ghr_m));
    check_lookup("debug_frozen", 32'h8000_0014, 1'b1, 1'b1, 3'd1);

    // Asynchronous reset in the middle of an update cycle
    bp_if.debug_mode_i = 1'b0;
    set_upd(1'b1, 32'h8000_0040, 1'b1, 3'd0);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_async_valid", 32'(bp_if.bht_pred_valid_o), 32'd0);
    check("rst_async_taken", 32'(bp_if.bht_pred_taken_o), 32'd0);
    check("rst_async_hist",  32'(bp_if.bht_hist_o), 32'd0);
    check("rst_async_ghr",   32'(bp_if.ghr_o), 32'd0);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 3'd0);
    rst_i = 1'b0;
    tick();
    check_lookup("rst_drop_idx16", 32'h8000_0040, 1'b0, 1'b0, 3'd0);
    check_lookup("rst_idx4", 32'h8000_0010, 1'b0, 1'b0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cva6_gshare_bht.md
# cva6_gshare_bht

Global-history branch history table for the cv32a60x-class frontend: 32 entries and 3 bits of global history, with no compressed instructions. It sits in the frontend beside the RAS. It takes the fetch PC, predicts taken/not-taken for conditional branches, and returns a history snapshot that travels with the instruction. The same snapshot comes back on the resolved-branch update port, so the update writes exactly the entry that was read.

## Interface
Parameters:
- XLEN, 32, PC width.
- BHT_ENTRIES, 32, number of 2-bit counters; power of two, ≥ 2^BHT_HIST.
- BHT_HIST, 3, global history register (GHR) length, ≥ 1.
- LOG_E, $clog2(BHT_ENTRIES), index width (derived, not overridable).

Ports (clock and reset):
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.

Ports (control and prediction):
- flush_bp_i  in  1  clears all predictor state.
- debug_mode_i  in  1  high = updates suppressed.
- vpc_valid_i  in  1  lookup request.
- vpc_i  in  XLEN  fetch PC of the branch.
- bht_pred_valid_o  out  1  prediction is meaningful.
- bht_pred_taken_o  out  1  predicted direction.
- bht_hist_o  out  BHT_HIST  GHR value used for this lookup.
- ghr_o  out  BHT_HIST  current GHR (visibility/verification).

Ports (resolved-branch update):
- upd_valid_i  in  1  resolved conditional branch.
- upd_pc_i  in  XLEN  PC of the resolved branch.
- upd_taken_i  in  1  actual direction.
- upd_hist_i  in  BHT_HIST  snapshot returned from bht_hist_o.

## Operation
State:
- cnt[BHT_ENTRIES], 2-bit saturating counters.
- vld[BHT_ENTRIES], 1 bit each.
- ghr, BHT_HIST bits.

Index function: idx(pc, h) = pc[LOG_E+1:2] XOR zero-extend(h) to LOG_E bits. pc[1:0] is ignored.

Lookup (combinational):
- ridx = idx(vpc_i, ghr).
- bht_pred_valid_o = vpc_valid_i & vld[ridx].
- bht_pred_taken_o = bht_pred_valid_o & cnt[ridx][1].
- bht_hist_o = ghr.

Update (when upd_valid_i & !debug_mode_i & !flush_bp_i):
- widx = idx(upd_pc_i, upd_hist_i).
- If vld[widx] = 0: cnt[widx] ← taken ? 2'b10 : 2'b01.
- Otherwise: taken increments the counter, saturating at 2'b11; not-taken decrements it, saturating at 2'b00.
- vld[widx] ← 1.
- ghr ← {ghr[BHT_HIST-2:0], upd_taken_i}. For BHT_HIST = 1, ghr ← upd_taken_i.

Flush: flush_bp_i high for one cycle sets every cnt to 2'b01, every vld to 0, and ghr to 0. Flush has priority over a simultaneous update; that update is dropped entirely.

Debug: with debug_mode_i high, counters and GHR are frozen. Lookups continue to work.

## Timing
- Reset: every cnt = 2'b01, every vld = 0, ghr = 0. Consequently bht_pred_valid_o = 0, bht_pred_taken_o = 0, bht_hist_o = 0 and ghr_o = 0.
- Reset is asynchronous on assertion and removed synchronously. Reset asserted mid-operation clears all state immediately, including any in-flight update.
- Lookup latency: 0 cycles, combinational from vpc_i/vpc_valid_i.
- Update latency: 1 cycle. The written counter and the new GHR are visible from the cycle after the update.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update (old) counter and vld. There is no bypass.
- The lookup in the update cycle uses the old GHR.
- One update per cycle. Back-to-back updates to the same index accumulate, one step per cycle.
- There are no handshakes: an update is accepted unconditionally every cycle it is valid.

## Test plan
- Reset, then lookup at vpc = 0x8000_0010 → pred_valid = 0, taken = 0, hist = 0.
- Taken update at pc = 0x8000_0010, hist 0 → idx 4 gets cnt = 2'b10 and ghr = 3'b001. Next cycle, a lookup with pc = 0x8000_0014 (idx 5 ^ 1 = 4) → pred_valid = 1, taken = 1, hist = 1.
- Four taken updates, then five not-taken updates, all with the same pc/hist → cnt steps 10→11→11→11→10→01→00→00→00. Saturation at both ends is checked each cycle.
- Lookup and update to the same index in the same cycle (entry invalid) → pred_valid = 0 that cycle and 1 the next cycle.
- flush_bp_i coincides with a taken update → all vld = 0, ghr = 0, and the update is not applied.
- debug_mode_i = 1 with three updates → ghr and counters unchanged. rst_i pulsed mid-sequence → all outputs return to 0 asynchronously.
